// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, halt encoding and the
// state encoding used by the program store.
package cpu_pkg;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RS_MSB = 5;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 2;
  localparam int RD_MSB = 1;
  localparam int RD_LSB = 0;

  // Jump-to-self encoding: a CPU fetching past the program parks here.
  localparam logic [7:0] HALT_INSTR = 8'b1100_0011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } store_state_e;

  function automatic logic [1:0] op_field(input logic [7:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_store_ram.sv
// Program byte array: synchronous write, asynchronous read, contents not reset.
module instr_store_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_store.sv
// Program memory responder for the CPU fetch port: loads a byte stream over a
// valid/ready port while holding the CPU in reset, then serves fetches.
module instr_store
  import cpu_pkg::*;
#(
  parameter int         DEPTH     = 32,
  parameter int         ADDR_W    = 5,
  parameter logic [7:0] FILL_WORD = HALT_INSTR
) (
  input  logic              origclk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [7:0]        pc,
  output logic [7:0]        instruction,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   prog_len,
  output logic [7:0]        load_sum,
  output logic              running
);

  store_state_e      r_state;
  store_state_e      w_next_state;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_prog_len;
  logic [7:0]        r_load_sum;

  logic              w_clear;
  logic              w_xfer;
  logic              w_end;
  logic [7:0]        w_rd_data;
  logic [8:0]        w_pc_ext;
  logic [8:0]        w_len_ext;

  assign w_clear = ((r_state == ST_IDLE) || (r_state == ST_RUN)) && load_start;
  assign w_xfer  = (r_state == ST_LOAD) && load_valid;
  // The final array slot closes the load even without load_last.
  assign w_end   = w_xfer && (load_last || (r_wptr == ADDR_W'(DEPTH - 1)));

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load_start) w_next_state = ST_LOAD;
        else            w_next_state = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_end) w_next_state = ST_START;
        else       w_next_state = ST_LOAD;
      end
      ST_START: w_next_state = ST_RUN;
      ST_RUN: begin
        if (load_start) w_next_state = ST_LOAD;
        else            w_next_state = ST_RUN;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, write pointer, length and checksum registers
  always_ff @(posedge origclk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wptr     <= '0;
      r_prog_len <= '0;
      r_load_sum <= 8'h00;
    end else begin
      r_state <= w_next_state;
      if (w_clear) begin
        r_wptr     <= '0;
        r_prog_len <= '0;
        r_load_sum <= 8'h00;
      end else if (w_xfer) begin
        r_wptr     <= r_wptr + ADDR_W'(1);
        r_load_sum <= r_load_sum + load_data;
        if (w_end) begin
          r_prog_len <= (ADDR_W + 1)'(r_wptr) + (ADDR_W + 1)'(1);
        end
      end
    end
  end

  instr_store_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (origclk),
    .i_we    (w_xfer),
    .i_waddr (r_wptr),
    .i_wdata (load_data),
    .i_raddr (pc[ADDR_W-1:0]),
    .o_rdata (w_rd_data)
  );

  // Full 8-bit pc compare so high address bits force the fill word.
  assign w_pc_ext  = {1'b0, pc};
  assign w_len_ext = 9'(r_prog_len);

  assign instruction = ((r_state == ST_RUN) && (w_pc_ext < w_len_ext)) ? w_rd_data : FILL_WORD;
  assign load_ready  = (r_state == ST_LOAD);
  assign cpu_reset   = (r_state != ST_RUN);
  assign running     = (r_state == ST_RUN);
  assign prog_len    = r_prog_len;
  assign load_sum    = r_load_sum;

endmodule

// File: tb/tb_instr_store.sv
// Randomized scoreboard bench for instr_store: the driver pushes expected
// observations, a negedge monitor pops and compares them.
module tb_instr_store;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              origclk = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic              load_valid = 1'b0;
  logic [7:0]        load_data = 8'h00;
  logic              load_last = 1'b0;
  logic [7:0]        pc = 8'h00;
  logic              load_ready;
  logic [7:0]        instruction;
  logic              cpu_reset;
  logic [ADDR_W:0]   prog_len;
  logic [7:0]        load_sum;
  logic              running;

  instr_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .origclk     (origclk),
    .reset       (reset),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .pc          (pc),
    .instruction (instruction),
    .cpu_reset   (cpu_reset),
    .prog_len    (prog_len),
    .load_sum    (load_sum),
    .running     (running)
  );

  always #5 origclk = ~origclk;

  typedef struct {
    int         kind;
    logic [8:0] val;
    logic [7:0] pc;
  } exp_t;

  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  string kind_name[6] = '{"instruction", "prog_len", "load_sum", "cpu_reset", "load_ready", "running"};

  // Reference model: the accepted program bytes and whether the CPU runs.
  logic [7:0] prog_q[$];
  logic [7:0] model_sum;
  bit         model_run;

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge origclk) begin
    while (exp_q.size() > 0) begin
      exp_t       e;
      logic [8:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = {1'b0, instruction};
        1:       act = {3'b000, prog_len};
        2:       act = {1'b0, load_sum};
        3:       act = {8'h00, cpu_reset};
        4:       act = {8'h00, load_ready};
        default: act = {8'h00, running};
      endcase
      n_cmp++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s pc=%0d actual=%0h expected=%0h t=%0t", kind_name[e.kind], e.pc, act, e.val, $time);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge origclk);
    #1;
  endtask

  task automatic push(input int kind, input logic [8:0] val);
    exp_q.push_back('{kind, val, pc});
  endtask

  function automatic logic [7:0] exp_instr(input logic [7:0] pcv);
    if (model_run && (int'(pcv) < prog_q.size())) return prog_q[pcv];
    return 8'hC3;
  endfunction

  task automatic check_status();
    push(1, 9'(prog_q.size()));
    push(2, {1'b0, model_sum});
    push(3, {8'h00, !model_run});
    push(4, 9'h000);
    push(5, {8'h00, model_run});
  endtask

  task automatic check_reads();
    int top;
    top = (prog_q.size() < DEPTH) ? prog_q.size() : DEPTH - 1;
    for (int i = 0; i <= top; i++) begin
      pc = 8'(i);
      push(0, {1'b0, exp_instr(pc)});
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      pc = 8'($urandom_range(0, 255));
      push(0, {1'b0, exp_instr(pc)});
      tick();
    end
  endtask

  task automatic model_clear();
    prog_q.delete();
    model_sum = 8'h00;
    model_run = 1'b0;
  endtask

  // Drive one program; abort_after >= 0 asserts reset after that many bytes.
  task automatic load_prog(input logic [7:0] bytes[$], input bit gap, input bit use_last, input int abort_after);
    bit last_now;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    model_clear();
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == abort_after) begin
        load_valid = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_clear();
        check_status();
        tick();
        check_reads();
        return;
      end
      if (gap) begin
        load_valid = 1'b0;
        load_last  = 1'($urandom_range(0, 1));
        load_data  = 8'($urandom_range(0, 255));
        load_start = 1'($urandom_range(0, 1));
        push(4, 9'h001);
        push(3, 9'h001);
        push(1, 9'h000);
        tick();
      end
      last_now   = use_last && (i == bytes.size() - 1);
      load_valid = 1'b1;
      load_data  = bytes[i];
      load_last  = last_now;
      load_start = ($urandom_range(0, 2) == 0);
      push(4, 9'h001);
      push(3, 9'h001);
      push(2, {1'b0, model_sum});
      tick();
      prog_q.push_back(bytes[i]);
      model_sum = model_sum + bytes[i];
      if (last_now || (prog_q.size() == DEPTH)) break;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_start = 1'b0;
    // START: still held in reset, loader closed.
    push(4, 9'h000);
    push(3, 9'h001);
    push(5, 9'h000);
    push(1, 9'(prog_q.size()));
    push(2, {1'b0, model_sum});
    tick();
    model_run = 1'b1;
    check_status();
    tick();
    check_reads();
  endtask

  function automatic void rand_bytes(input int n, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
  endfunction

  initial begin
    logic [7:0] bq[$];
    int         n;
    bit         ul;
    model_clear();
    #10;
    reset = 1'b0;
    tick();
    check_status();
    check_reads();

    bq = '{8'h44, 8'h49, 8'h19, 8'h84};
    load_prog(bq, 1'b0, 1'b1, -1);
    push(2, 9'h02A);
    push(1, 9'd4);
    tick();

    pc = 8'd0;
    #1;
    n_cmp++;
    if (instruction !== 8'h44) begin
      n_fail++;
      $display("FAIL direct instruction pc=0 actual=%0h expected=44 t=%0t", instruction, $time);
    end
    pc = 8'd3;
    #1;
    n_cmp++;
    if (instruction !== 8'h84) begin
      n_fail++;
      $display("FAIL direct instruction pc=3 actual=%0h expected=84 t=%0t", instruction, $time);
    end
    pc = 8'd4;
    #1;
    n_cmp++;
    if (instruction !== 8'hC3) begin
      n_fail++;
      $display("FAIL direct instruction pc=4 actual=%0h expected=c3 t=%0t", instruction, $time);
    end
    n_cmp++;
    if (prog_len !== 6'd4) begin
      n_fail++;
      $display("FAIL direct prog_len actual=%0d expected=4 t=%0t", prog_len, $time);
    end
    n_cmp++;
    if (load_sum !== 8'h2A) begin
      n_fail++;
      $display("FAIL direct load_sum actual=%0h expected=2a t=%0t", load_sum, $time);
    end
    n_cmp++;
    if (cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL direct cpu_reset actual=%0b expected=0 t=%0t", cpu_reset, $time);
    end
    tick();

    rand_bytes(21, bq);
    load_prog(bq, 1'b1, 1'b1, -1);

    rand_bytes(DEPTH, bq);
    load_prog(bq, 1'b0, 1'b0, -1);
    pc = 8'd32;
    push(0, 9'h0C3);
    push(1, 9'd32);
    tick();

    bq = '{8'h00};
    load_prog(bq, 1'b0, 1'b1, -1);

    rand_bytes(5, bq);
    load_prog(bq, 1'b0, 1'b1, 2);
    load_prog(bq, 1'b0, 1'b1, -1);

    // Reset and load_start together: reset wins, store stays idle.
    reset = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    reset = 1'b0;
    model_clear();
    tick();
    check_status();
    tick();

    for (int k = 0; k < 6; k++) begin
      n  = $urandom_range(1, 40);
      ul = (n <= DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      rand_bytes(n, bq);
      load_prog(bq, 1'($urandom_range(0, 1)), ul, -1);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    if (n_fail != 0) $display("FAIL");
    else             $display("PASS");
    $finish;
  end

endmodule
